// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: source select, load extraction, one-entry hold, commit counter
module wb_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int LINK_OFFSET    = 4,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      in_valid_i,
   input  logic [2:0]                sel_i,
   input  logic                      link_i,
   input  logic [DATA_WIDTH-1:0]     pc_i,
   input  logic [DATA_WIDTH-1:0]     alu_i,
   input  logic [DATA_WIDTH-1:0]     mem_i,
   input  logic [DATA_WIDTH-1:0]     imm_i,
   input  logic [1:0]                load_size_i,
   input  logic                      load_unsigned_i,
   input  logic [1:0]                byte_off_i,
   input  logic [REG_ADDR_WIDTH-1:0] rd_i,
   input  logic                      rd_we_i,
   input  logic                      flush_i,
   input  logic                      out_ready_i,
   output logic                      in_ready_o,
   output logic                      out_valid_o,
   output logic                      rf_we_o,
   output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
   output logic [DATA_WIDTH-1:0]     rf_wdata_o,
   output logic [CNT_WIDTH-1:0]      commits_o
);

   logic                      r_valid;
   logic                      r_we;
   logic [REG_ADDR_WIDTH-1:0] r_waddr;
   logic [DATA_WIDTH-1:0]     r_wdata;
   logic [CNT_WIDTH-1:0]      r_commits;

   logic [7:0]                w_byte;
   logic [15:0]               w_half;
   logic [DATA_WIDTH-1:0]     w_load;
   logic [DATA_WIDTH-1:0]     w_sel_data;
   logic                      w_accept;

   always_comb begin
      w_byte = 8'h00;
      case (byte_off_i)
         2'd0:    w_byte = mem_i[7:0];
         2'd1:    w_byte = mem_i[15:8];
         2'd2:    w_byte = mem_i[23:16];
         default: w_byte = mem_i[31:24];
      endcase
      w_half = byte_off_i[1] ? mem_i[31:16] : mem_i[15:0];
      case (load_size_i)
         2'b00:   w_load = {{(DATA_WIDTH-8){w_byte[7] & ~load_unsigned_i}}, w_byte};
         2'b01:   w_load = {{(DATA_WIDTH-16){w_half[15] & ~load_unsigned_i}}, w_half};
         default: w_load = mem_i;
      endcase
   end

   always_comb begin
      w_sel_data = '0;
      case (sel_i)
         3'b000:  w_sel_data = link_i ? (pc_i + DATA_WIDTH'(LINK_OFFSET)) : pc_i;
         3'b001:  w_sel_data = alu_i;
         3'b010:  w_sel_data = w_load;
         3'b011:  w_sel_data = imm_i;
         default: w_sel_data = '0;
      endcase
   end

   assign in_ready_o = (!r_valid || out_ready_i) && !flush_i;
   assign w_accept   = in_valid_i && in_ready_o;

   // Flush and reset both kill the strobe in the same cycle they are asserted.
   assign rf_we_o     = r_valid && out_ready_i && r_we && (r_waddr != '0) && !flush_i && !rst_i;
   assign out_valid_o = r_valid;
   assign rf_waddr_o  = r_waddr;
   assign rf_wdata_o  = r_wdata;
   assign commits_o   = r_commits;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid   <= 1'b0;
         r_we      <= 1'b0;
         r_waddr   <= '0;
         r_wdata   <= '0;
         r_commits <= '0;
      end else begin
         if (rf_we_o) begin
            r_commits <= r_commits + 1'b1;
         end
         if (flush_i) begin
            r_valid <= 1'b0;
         end else if (w_accept) begin
            r_valid <= 1'b1;
            r_we    <= rd_we_i;
            r_waddr <= rd_i;
            r_wdata <= w_sel_data;
         end else if (out_ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed bench for wb_stage, with a narrow-counter instance for wrap checks
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [2:0]  sel;
   logic        link;
   logic [31:0] pc, alu, mem, imm;
   logic [1:0]  load_size;
   logic        load_unsigned;
   logic [1:0]  byte_off;
   logic [4:0]  rd;
   logic        rd_we;
   logic        flush;
   logic        out_ready;

   logic        in_ready, out_valid, rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] commits;

   logic        in_ready2, out_valid2, rf_we2;
   logic [4:0]  rf_waddr2;
   logic [31:0] rf_wdata2;
   logic [1:0]  commits2;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .sel_i(sel), .link_i(link),
      .pc_i(pc), .alu_i(alu), .mem_i(mem), .imm_i(imm), .load_size_i(load_size),
      .load_unsigned_i(load_unsigned), .byte_off_i(byte_off), .rd_i(rd), .rd_we_i(rd_we),
      .flush_i(flush), .out_ready_i(out_ready), .in_ready_o(in_ready), .out_valid_o(out_valid),
      .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .commits_o(commits)
   );

   wb_stage #(.CNT_WIDTH(2)) dut2 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .sel_i(sel), .link_i(link),
      .pc_i(pc), .alu_i(alu), .mem_i(mem), .imm_i(imm), .load_size_i(load_size),
      .load_unsigned_i(load_unsigned), .byte_off_i(byte_off), .rd_i(rd), .rd_we_i(rd_we),
      .flush_i(flush), .out_ready_i(out_ready), .in_ready_o(in_ready2), .out_valid_o(out_valid2),
      .rf_we_o(rf_we2), .rf_waddr_o(rf_waddr2), .rf_wdata_o(rf_wdata2), .commits_o(commits2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_load(input string tag, input logic [1:0] size, input logic [1:0] off,
                          input logic uns, input logic [31:0] exp);
      in_valid = 1'b1; sel = 3'b010; mem = 32'h1234_80FF;
      load_size = size; byte_off = off; load_unsigned = uns; rd = 5'd2; rd_we = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
      chk(tag, rf_wdata, exp);
      tick();
   endtask

   logic [1:0] wrap_exp [5];

   initial begin
      wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
      wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

      rst = 1'b1; in_valid = 1'b0; sel = 3'b000; link = 1'b0;
      pc = '0; alu = '0; mem = '0; imm = '0; load_size = 2'b00; load_unsigned = 1'b0;
      byte_off = 2'b00; rd = '0; rd_we = 1'b0; flush = 1'b0; out_ready = 1'b1;
      tick(); tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      chk("rst_commits", commits, 32'd0);
      chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // link write
      in_valid = 1'b1; sel = 3'b000; link = 1'b1; pc = 32'h8000_0000; rd = 5'd1; rd_we = 1'b1;
      tick();
      in_valid = 1'b0; link = 1'b0;
      #1;
      chk("link_valid", {31'd0, out_valid}, 32'd1);
      chk("link_wdata", rf_wdata, 32'h8000_0004);
      chk("link_rf_we", {31'd0, rf_we}, 32'd1);
      chk("link_commits_before", commits, 32'd0);
      tick();
      chk("link_commits_after", commits, 32'd1);
      chk("link_drained", {31'd0, out_valid}, 32'd0);

      do_load("load_b1_signed", 2'b00, 2'd1, 1'b0, 32'hFFFF_FF80);
      do_load("load_h2_unsigned", 2'b01, 2'd2, 1'b1, 32'h0000_1234);
      do_load("load_b0_unsigned", 2'b00, 2'd0, 1'b1, 32'h0000_00FF);
      chk("load_commits", commits, 32'd4);

      // backpressure
      in_valid = 1'b1; sel = 3'b001; alu = 32'hA; rd = 5'd3; rd_we = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         alu = 32'hB + i; rd = 5'd9; in_valid = 1'b1;
         #1;
         chk("bp_wdata", rf_wdata, 32'hA);
         chk("bp_waddr", {27'd0, rf_waddr}, 32'd3);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_rf_we", {31'd0, rf_we}, 32'd0);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk("bp_release_we", {31'd0, rf_we}, 32'd1);
      tick();
      chk("bp_commits", commits, 32'd5);
      chk("bp_drained_we", {31'd0, rf_we}, 32'd0);

      // write to x0 never strobes
      in_valid = 1'b1; sel = 3'b001; alu = 32'h7; rd = 5'd0; rd_we = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
      chk("x0_valid", {31'd0, out_valid}, 32'd1);
      chk("x0_rf_we", {31'd0, rf_we}, 32'd0);
      tick();
      chk("x0_commits", commits, 32'd5);

      // back-to-back, one write per cycle
      in_valid = 1'b1; alu = 32'd100; rd = 5'd1;
      tick();
      for (int i = 0; i < 4; i++) begin
         alu = 32'd101 + i; rd = 5'(i + 2); in_valid = (i < 3);
         #1;
         chk("b2b_valid", {31'd0, out_valid}, 32'd1);
         chk("b2b_rf_we", {31'd0, rf_we}, 32'd1);
         chk("b2b_wdata", rf_wdata, 32'd100 + i);
         chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
         tick();
      end
      chk("b2b_commits", commits, 32'd9);
      chk("b2b_drained", {31'd0, out_valid}, 32'd0);

      // flush of a held entry
      in_valid = 1'b1; alu = 32'h55; rd = 5'd4;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      tick();
      chk("flush_held", {31'd0, out_valid}, 32'd1);
      flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      #1;
      chk("flush_rf_we", {31'd0, rf_we}, 32'd0);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_commits", commits, 32'd9);

      // reset of a held entry
      in_valid = 1'b1; alu = 32'h66; rd = 5'd5;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      tick();
      rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      #1;
      chk("rstmid_rf_we", {31'd0, rf_we}, 32'd0);
      tick();
      chk("rstmid_valid", {31'd0, out_valid}, 32'd0);
      chk("rstmid_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("rstmid_wdata", rf_wdata, 32'd0);
      chk("rstmid_commits", commits, 32'd0);
      chk("rstmid_commits2", {30'd0, commits2}, 32'd0);
      rst = 1'b0; in_valid = 1'b0;
      tick();

      // narrow counter wrap
      in_valid = 1'b1; sel = 3'b011; imm = 32'h1; rd = 5'd1; rd_we = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         in_valid = (i < 4);
         tick();
         chk("wrap_commits2", {30'd0, commits2}, {30'd0, wrap_exp[i]});
      end
      chk("wrap_commits_wide", commits, 32'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
